rib_ws_ram: RTL and testbench
=============================

RIB_WS_RAM -- requirements
Module: rib_ws_ram

Interface
REQ-001 Parameter ADDR_BASE, default 32'h2000_0000: base of the 1 KiB decoded window; bits [9:0] of the parameter are ignored.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 0..15: added wait states per access.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_i  input  1  bus access request from the initiator, held until the access completes.
REQ-006 Port we_i  input  1  1 = write, 0 = read.
REQ-007 Port addr_i  input  32  byte address.
REQ-008 Port data_i  input  32  write data.
REQ-009 Port data_o  output  32  read data.
REQ-010 Port hold_o  output  1  stall request to the initiator; combinational.

Function
REQ-011 hit = req_i & (addr_i[31:10] == ADDR_BASE[31:10]).
REQ-012 Storage: 256 x 32-bit words, indexed by addr_i[9:2]; addr_i[1:0] ignored; full-word accesses only.
REQ-013 FSM states: IDLE, BUSY, ACK.
REQ-014 Capture registers: addr_q, we_q, wdata_q; 4-bit wait counter cnt; 32-bit rdata_q.
REQ-015 IDLE, hit=1: capture addr_i/we_i/data_i, load cnt=WAIT_CYCLES, go BUSY.
REQ-016 IDLE, hit=0: stay IDLE; no capture.
REQ-017 BUSY, abort condition (req_i=0, or addr_i!=addr_q, or we_i!=we_q): go IDLE; no RAM write.
REQ-018 BUSY, no abort, cnt!=0: decrement cnt; stay BUSY.
REQ-019 BUSY, no abort, cnt==0, write: RAM[addr_q[9:2]] <= wdata_q; go ACK.
REQ-020 BUSY, no abort, cnt==0, read: rdata_q <= RAM[addr_q[9:2]]; go ACK.
REQ-021 ACK: always go IDLE next cycle, regardless of req_i.
REQ-022 hold_o = hit & (state != ACK). Miss: hold_o=0. ACK: hold_o=0.
REQ-023 data_o = rdata_q when state==ACK and we_q==0; otherwise 32'h0.
REQ-024 Timing for an uninterrupted access: hold_o high for exactly WAIT_CYCLES+2 cycles, from the first request cycle. The ACK cycle follows, with hold_o=0 and read data valid.
REQ-025 Back-to-back accesses: a request present in the cycle after ACK is accepted in IDLE with no extra bubble.
REQ-026 An aborted access may be re-presented immediately; it restarts from IDLE with a full wait count.
REQ-027 A write is committed exactly once per completed access and never for an aborted one.
REQ-028 rdata_q changes only on a read completion.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, cnt=0, addr_q=0, we_q=0, wdata_q=0, rdata_q=0, data_o=0.
REQ-030 Reset asserted mid-access: the access is dropped and the pending write is not performed.
REQ-031 RAM contents are not initialized by reset.
REQ-032 After reset deassertion, the first hit is accepted on the next rising edge.

Verification
REQ-033 Write then read, WAIT_CYCLES=2: write 32'hDEAD_BEEF to 0x2000_0010 -> hold_o high 4 cycles, then one ACK cycle. Read of 0x2000_0010 -> hold high 4 cycles; data_o=32'hDEAD_BEEF in the ACK cycle only.
REQ-034 WAIT_CYCLES=0: read of 0x2000_03FC -> hold_o high 2 cycles, then ACK with the stored word. Byte addresses 0x2000_03FD..0x2000_03FF alias to the same word.
REQ-035 Miss: req_i=1 with addr 0x3000_0000 -> hold_o=0, data_o=0, state remains IDLE, RAM unchanged.
REQ-036 Abort: start a write of 32'h1234_5678 to 0x2000_0020; drop req_i in the 2nd BUSY cycle -> FSM to IDLE; a subsequent read of 0x2000_0020 returns the old value.
REQ-037 Reset mid-write: assert rst during BUSY -> hold_o=0 and data_o=0 immediately; the target word is unchanged when read after reset.
REQ-038 Back-to-back: 4 consecutive reads of 0x2000_0000..0x2000_000C with WAIT_CYCLES=1 -> each access takes exactly 4 cycles (3 hold + 1 ACK); total 16 cycles; data correct for each.

Source files
------------

// File: rtl/rib_ws_ram.sv
// rib_ws_ram: 1 KiB single-port RAM slave on the RIB bus with a fixed number of wait states.
//
// An access that hits the decoded window is captured in IDLE. It then spends WAIT_CYCLES+1
// cycles in BUSY. A single ACK cycle follows, in which read data is presented.
// The initiator is stalled through hold_o while the access is pending. Changing or dropping
// the request before completion aborts the access without side effects.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   req_i   access request, held by the initiator until completion
//   we_i    1 = write, 0 = read
//   addr_i  byte address (word-aligned; bits [1:0] ignored)
//   data_i  write data
//   data_o  read data, valid in the ACK cycle of a read, zero otherwise
//   hold_o  combinational stall request to the initiator

module rib_ws_ram #(
  parameter logic [31:0] ADDR_BASE   = 32'h2000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hold_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [256];
  logic        mem_we;

  logic hit;
  logic abort;

  assign hit = req_i & (addr_i[31:10] == ADDR_BASE[31:10]);

  // The initiator must present exactly the captured access for the whole wait period.
  assign abort = ~req_i | (addr_i != addr_q) | (we_i != we_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          addr_d  = addr_i;
          we_d    = we_i;
          wdata_d = data_i;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (we_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q[9:2]];
          end
          state_d = StAck;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset. A write only fires from BUSY, which reset leaves immediately.
  // The rst term guards the edge on which reset is being asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[addr_q[9:2]] <= wdata_q;
    end
  end

  // The stall is forced low during reset so the initiator sees the access dropped at once.
  assign hold_o = hit & (state_q != StAck) & ~rst;
  assign data_o = ((state_q == StAck) && !we_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_rib_ws_ram.sv
// Testbench for rib_ws_ram. Three instances with WAIT_CYCLES = 2, 0 and 1 share clock and reset.
// Each access is checked for stall length and for ACK data against a word-array model.
module tb_rib_ws_ram;

  localparam int NI = 3;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] dout  [NI];
  logic        hold  [NI];

  int wait_of [NI] = '{2, 0, 1};

  int checks   = 0;
  int failures = 0;

  // Reference storage: one word array per instance plus written flags (RAM is not reset).
  logic [31:0] mem_m [NI][256];
  bit          vld_m [NI][256];
  int          last_n;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rib_ws_ram #(
      .ADDR_BASE  (BASE),
      .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 0 : 1))
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req_i (req[g]),
      .we_i  (we[g]),
      .addr_i(addr[g]),
      .data_i(wdata[g]),
      .data_o(dout[g]),
      .hold_o(hold[g])
    );
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Entered at posedge+1. Presents one access and follows it to its ACK cycle.
  // Returns at posedge+2 inside the ACK cycle with the request still driven.
  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
    int n;
    bit done;
    logic [31:0] exp;
    n = 0;
    done = 1'b0;
    req[k] = 1'b1;
    we[k] = w;
    addr[k] = a;
    wdata[k] = d;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (hold[k] === 1'b1) begin
        checks++;
        if (dout[k] !== 32'h0) begin
          failures++;
          $display("FAIL %s data_during_hold inst%0d got=%h exp=0", tag, k, dout[k]);
        end
        n++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    last_n = n;
    checks++;
    if (n != wait_of[k] + 2) begin
      failures++;
      $display("FAIL %s hold_cycles inst%0d got=%0d exp=%0d", tag, k, n, wait_of[k] + 2);
    end
    if (w) begin
      checks++;
      if (dout[k] !== 32'h0) begin
        failures++;
        $display("FAIL %s write_ack_data inst%0d got=%h exp=0", tag, k, dout[k]);
      end
      mem_m[k][a[9:2]] = d;
      vld_m[k][a[9:2]] = 1'b1;
    end else if (vld_m[k][a[9:2]]) begin
      exp = mem_m[k][a[9:2]];
      checks++;
      if (dout[k] !== exp) begin
        failures++;
        $display("FAIL %s read_data inst%0d addr=%h got=%h exp=%h", tag, k, a, dout[k], exp);
      end
    end
  endtask

  // Drops the request and moves to posedge+1 of the next cycle (FSM back in IDLE).
  task automatic drop_req(input int k);
    req[k] = 1'b0;
    we[k] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (dout[k] !== 32'h0 || hold[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs inst%0d data=%h hold=%b exp data=0 hold=0", k, dout[k],
                 hold[k]);
      end
    end
    @(posedge clk);
    #1;
    req[0] = 1'b1;
    we[0] = 1'b0;
    addr[0] = BASE + 32'h100;
    #1;
    checks++;
    if (hold[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold_with_hit got=%b exp=0", hold[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // First hit after release must be taken on the very next edge: full-length stall only.
    access(0, 1'b0, BASE + 32'h100, 32'h0, "first_after_reset");
    drop_req(0);
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, "wr_deadbeef");
    drop_req(0);
    access(0, 1'b0, 32'h2000_0010, 32'h0, "rd_deadbeef");
    checks++;
    if (dout[0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_deadbeef_const got=%h exp=deadbeef", dout[0]);
    end
    drop_req(0);
    checks++;
    if (dout[0] !== 32'h0) begin
      failures++;
      $display("FAIL data_after_ack got=%h exp=0", dout[0]);
    end
  endtask

  task automatic test_alias();
    logic [31:0] v;
    v = $urandom;
    access(1, 1'b1, 32'h2000_03FC, v, "alias_wr");
    drop_req(1);
    for (int i = 0; i < 4; i++) begin
      access(1, 1'b0, 32'h2000_03FC + i, 32'h0, "alias_rd");
      checks++;
      if (dout[1] !== v) begin
        failures++;
        $display("FAIL alias_rd_%0d got=%h exp=%h", i, dout[1], v);
      end
      drop_req(1);
    end
  endtask

  task automatic test_miss();
    access(1, 1'b1, 32'h2000_0044, 32'hA5A5_0001, "miss_pre_wr");
    drop_req(1);
    req[1] = 1'b1;
    we[1] = 1'b1;
    addr[1] = 32'h3000_0044;
    wdata[1] = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (hold[1] !== 1'b0 || dout[1] !== 32'h0) begin
        failures++;
        $display("FAIL miss_outputs cyc%0d hold=%b data=%h exp hold=0 data=0", c, hold[1],
                 dout[1]);
      end
      @(posedge clk);
      #1;
    end
    drop_req(1);
    access(1, 1'b0, 32'h2000_0044, 32'h0, "miss_post_rd");
    drop_req(1);
  endtask

  task automatic test_abort();
    access(0, 1'b1, 32'h2000_0020, 32'hCAFE_0020, "abort_pre_wr");
    drop_req(0);
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 32'h2000_0020;
    wdata[0] = 32'h1234_5678;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    #1;
    checks++;
    if (hold[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold got=%b exp=0", hold[0]);
    end
    @(posedge clk);
    #1;
    access(0, 1'b0, 32'h2000_0020, 32'h0, "abort_post_rd");
    drop_req(0);
  endtask

  task automatic test_reset_mid_write();
    access(0, 1'b1, 32'h2000_0040, 32'h0BAD_F00D, "rst_pre_wr");
    drop_req(0);
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 32'h2000_0040;
    wdata[0] = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (hold[0] !== 1'b0 || dout[0] !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs hold=%b data=%h exp hold=0 data=0", hold[0], dout[0]);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(0, 1'b0, 32'h2000_0040, 32'h0, "rst_post_rd");
    drop_req(0);
  endtask

  task automatic test_back_to_back();
    int total;
    for (int i = 0; i < 4; i++) begin
      access(2, 1'b1, BASE + 32'(4 * i), $urandom, "b2b_pre_wr");
      drop_req(2);
    end
    total = 0;
    for (int i = 0; i < 4; i++) begin
      access(2, 1'b0, BASE + 32'(4 * i), 32'h0, "b2b_rd");
      total += last_n + 1;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (total != 16) begin
      failures++;
      $display("FAIL b2b_total_cycles got=%0d exp=16", total);
    end
    drop_req(2);
  endtask

  task automatic test_random();
    int r;
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 40; i++) begin
        r = $urandom_range(0, 9);
        a = BASE | {22'h0, 8'($urandom_range(0, 15)), 2'($urandom)};
        if (r < 2) begin
          req[k] = 1'b1;
          we[k] = 1'($urandom);
          addr[k] = a ^ 32'h4000_0000;
          wdata[k] = $urandom;
          #1;
          checks++;
          if (hold[k] !== 1'b0 || dout[k] !== 32'h0) begin
            failures++;
            $display("FAIL rand_miss inst%0d hold=%b data=%h exp hold=0 data=0", k, hold[k],
                     dout[k]);
          end
          @(posedge clk);
          #1;
        end else begin
          access(k, r < 5, a, $urandom, "rand_acc");
        end
        drop_req(k);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0;
      we[k] = 1'b0;
      addr[k] = 32'h0;
      wdata[k] = 32'h0;
      for (int j = 0; j < 256; j++) begin
        vld_m[k][j] = 1'b0;
        mem_m[k][j] = 32'h0;
      end
    end
    rst = 1'b1;
    @(posedge clk);
    test_reset();
    test_write_read();
    test_alias();
    test_miss();
    test_abort();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
